// File: rtl/la_cellbist_if.sv
// Bundle of the control, CUT-facing and result signals of the cell BIST
// sequencer. The master side (controller / cell wrapper) drives start, abort
// and the CUT output; the slave side (la_cellbist) drives the pattern and the
// test results.
interface la_cellbist_if #(
   parameter int N = 5
);
   logic         start;
   logic         abort;
   logic         z_in;
   logic [N-1:0] pat;
   logic         busy;
   logic         done;
   logic         pass;
   logic [N:0]   fail_count;
   logic [N-1:0] first_fail;

   modport master (
      output start, abort, z_in,
      input  pat, busy, done, pass, fail_count, first_fail
   );

   modport slave (
      input  start, abort, z_in,
      output pat, busy, done, pass, fail_count, first_fail
   );
endinterface

// File: rtl/la_cellbist.sv
// Exhaustive BIST sequencer for a small combinational stdlib cell.
// Walks every N-bit input pattern, waits SETTLE cycles for the cell to
// settle, samples its output against the truth table TT and records the
// number of failing patterns plus the index of the first failure.
module la_cellbist #(
   parameter int                N      = 5,
   parameter logic [(1<<N)-1:0] TT     = 32'h007F7F7F,
   parameter int                SETTLE = 1,
   parameter                    PROP   = "DEFAULT"
) (
   input logic         clk,
   input logic         nreset,
   la_cellbist_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [N-1:0] LAST_PAT    = {N{1'b1}};
   localparam logic [N:0]   FAIL_MAX    = {1'b1, {N{1'b0}}};
   localparam logic [N:0]   FAIL_ZERO   = {(N+1){1'b0}};
   localparam logic [N:0]   FAIL_ONE    = {{N{1'b0}}, 1'b1};
   localparam logic [N-1:0] PAT_ZERO    = {N{1'b0}};
   localparam logic [N-1:0] PAT_ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [3:0]   SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   // With no settle time each pattern goes straight to its sample cycle.
   localparam state_t       FIRST_STATE = (SETTLE == 0) ? S_SAMPLE : S_APPLY;

   // The property string only tags the implementation variant; it selects no logic.
   if (PROP == "DEFAULT") begin : g_prop_default
   end else begin : g_prop_custom
   end

   state_t       state_r, state_s;
   logic [N-1:0] pat_r, pat_s;
   logic [3:0]   settle_r, settle_s;
   logic [N:0]   fail_count_r, fail_count_s;
   logic [N-1:0] first_fail_r, first_fail_s;
   logic         busy_r, busy_s;
   logic         done_r, done_s;
   logic         pass_r, pass_s;
   logic         mismatch_s;

   // Next-state and next-result computation; abort overrides everything.
   always_comb begin
      state_s      = state_r;
      pat_s        = pat_r;
      settle_s     = settle_r;
      fail_count_s = fail_count_r;
      first_fail_s = first_fail_r;
      busy_s       = busy_r;
      done_s       = done_r;
      pass_s       = pass_r;
      mismatch_s   = (bus.z_in != TT[pat_r]);

      if (bus.abort) begin
         // Counters are kept so the partial result can still be inspected.
         state_s  = S_IDLE;
         pat_s    = PAT_ZERO;
         settle_s = 4'd0;
         busy_s   = 1'b0;
         done_s   = 1'b0;
         pass_s   = 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_s      = FIRST_STATE;
                  pat_s        = PAT_ZERO;
                  settle_s     = SETTLE_LOAD;
                  fail_count_s = FAIL_ZERO;
                  first_fail_s = PAT_ZERO;
                  busy_s       = 1'b1;
                  done_s       = 1'b0;
                  pass_s       = 1'b0;
               end else begin
                  state_s = state_r;
               end
            end
            S_APPLY: begin
               if (settle_r == 4'd0) begin
                  state_s = S_SAMPLE;
               end else begin
                  settle_s = settle_r - 4'd1;
               end
            end
            S_SAMPLE: begin
               if (mismatch_s && (fail_count_r != FAIL_MAX)) begin
                  fail_count_s = fail_count_r + FAIL_ONE;
                  if (fail_count_r == FAIL_ZERO) begin
                     first_fail_s = pat_r;
                  end else begin
                     first_fail_s = first_fail_r;
                  end
               end else begin
                  fail_count_s = fail_count_r;
               end
               if (pat_r == LAST_PAT) begin
                  state_s = S_DONE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  pass_s  = (fail_count_r == FAIL_ZERO) && !mismatch_s;
               end else begin
                  state_s  = FIRST_STATE;
                  pat_s    = pat_r + PAT_ONE;
                  settle_s = SETTLE_LOAD;
               end
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end
   end

   // State and result registers with asynchronous clear.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r      <= S_IDLE;
         pat_r        <= PAT_ZERO;
         settle_r     <= 4'd0;
         fail_count_r <= FAIL_ZERO;
         first_fail_r <= PAT_ZERO;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         pat_r        <= pat_s;
         settle_r     <= settle_s;
         fail_count_r <= fail_count_s;
         first_fail_r <= first_fail_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         pass_r       <= pass_s;
      end
   end

   assign bus.pat        = pat_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.pass       = pass_r;
   assign bus.fail_count = fail_count_r;
   assign bus.first_fail = first_fail_r;

endmodule

// File: tb/tb_la_cellbist.sv
// Scoreboard bench for la_cellbist: three builds (SETTLE = 0, 1, 3) around a
// behavioural aoi32 cell with selectable faults. Stimulus pushes the expected
// result of each full run; a monitor pops and compares on every rising done.
module tb_la_cellbist;

   logic clk;
   logic nreset;
   int   cyc;
   int   mode;
   int   checks;
   int   errors;
   bit   track_pat;
   int   trk_start;

   typedef struct {
      int id;
      int edge_no;
      int fc;
      int ff;
      int ps;
   } exp_t;

   exp_t sb[$];

   la_cellbist_if #(.N(5)) b0 ();
   la_cellbist_if #(.N(5)) b1 ();
   la_cellbist_if #(.N(5)) b3 ();

   la_cellbist #(.N(5), .SETTLE(0)) u_s0 (.clk(clk), .nreset(nreset), .bus(b0));
   la_cellbist #(.N(5), .SETTLE(1)) u_s1 (.clk(clk), .nreset(nreset), .bus(b1));
   la_cellbist #(.N(5), .SETTLE(3)) u_s3 (.clk(clk), .nreset(nreset), .bus(b3));

   // Cell under test: aoi32 with pat[0]=a0 .. pat[4]=b1, plus fault modes.
   function automatic logic cut(input logic [4:0] p, input int m);
      case (m)
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return ~(p[0] & p[1] & p[2]);
         default: return ~((p[0] & p[1] & p[2]) | (p[3] & p[4]));
      endcase
   endfunction

   assign b0.z_in = cut(b0.pat, mode);
   assign b1.z_in = cut(b1.pat, mode);
   assign b3.z_in = cut(b3.pat, mode);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic f_done(input int id);
      case (id)
         0:       return b0.done;
         1:       return b1.done;
         default: return b3.done;
      endcase
   endfunction

   function automatic logic f_busy(input int id);
      case (id)
         0:       return b0.busy;
         1:       return b1.busy;
         default: return b3.busy;
      endcase
   endfunction

   task automatic set_start(input int id, input logic v);
      case (id)
         0:       b0.start = v;
         1:       b1.start = v;
         default: b3.start = v;
      endcase
   endtask

   task automatic wait_done(input int id, input int limit);
      int n = 0;
      while (!f_done(id) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!f_done(id)) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: dut %0d got done=0 expected done=1 within %0d cycles", id, limit);
      end
   endtask

   task automatic wait_pat1(input int value, input int limit);
      int n = 0;
      while (int'(b1.pat) != value && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_pat", b1.pat, value);
   endtask

   // One full run: pulse start, register the expected result, optionally poke
   // start again while busy, then wait for completion.
   task automatic run(input int id, input int lat, input int fc, input int ff,
                      input int ps, input int poke);
      int se;
      exp_t e;
      @(negedge clk);
      set_start(id, 1'b1);
      se = cyc + 1;
      e.id = id; e.edge_no = se + lat; e.fc = fc; e.ff = ff; e.ps = ps;
      sb.push_back(e);
      if (id == 1) trk_start = se;
      @(negedge clk);
      set_start(id, 1'b0);
      check("busy_after_start", f_busy(id), 1);
      if (poke > 0) begin
         repeat (poke) @(negedge clk);
         set_start(id, 1'b1);
         @(negedge clk);
         set_start(id, 1'b0);
      end
      wait_done(id, lat + 10);
   endtask

   // Monitor: compare each completed run against the front of the scoreboard.
   logic [2:0] done_prev;
   always @(negedge clk) begin
      logic [2:0] dn;
      dn = {b3.done, b1.done, b0.done};
      if (track_pat && b1.busy)
         check("pat_seq", b1.pat, (cyc - trk_start) / 2);
      for (int i = 0; i < 3; i++) begin
         if (dn[i] && !done_prev[i]) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: dut %0d got done=1 expected no result pending", i);
            end else begin
               exp_t e;
               logic [5:0] fc;
               logic [4:0] ff;
               logic [4:0] pt;
               logic       ps;
               e = sb.pop_front();
               case (i)
                  0:       begin fc = b0.fail_count; ff = b0.first_fail; pt = b0.pat; ps = b0.pass; end
                  1:       begin fc = b1.fail_count; ff = b1.first_fail; pt = b1.pat; ps = b1.pass; end
                  default: begin fc = b3.fail_count; ff = b3.first_fail; pt = b3.pat; ps = b3.pass; end
               endcase
               check("sb_dut", i, e.id);
               check("done_edge", cyc, e.edge_no);
               check("fail_count", fc, e.fc);
               check("first_fail", ff, e.ff);
               check("pass", ps, e.ps);
               check("pat_at_done", pt, 31);
            end
         end
      end
      done_prev <= dn;
   end

   initial begin
      checks = 0; errors = 0; mode = 0; track_pat = 1'b0; trk_start = 0;
      done_prev = 3'b000;
      nreset = 1'b0;
      b0.start = 1'b0; b0.abort = 1'b0;
      b1.start = 1'b0; b1.abort = 1'b0;
      b3.start = 1'b0; b3.abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pat", b1.pat, 0);
      check("rst_busy", b1.busy, 0);
      check("rst_done", b1.done, 0);
      check("rst_pass", b1.pass, 0);
      check("rst_fail_count", b1.fail_count, 0);
      check("rst_first_fail", b1.first_fail, 0);
      nreset = 1'b1;

      // Fault-free, then stuck-at-1, stuck-at-0 and b1 stuck-at-0 (restarts from DONE).
      mode = 0; track_pat = 1'b1;
      run(1, 64, 0, 0, 1, 0);
      track_pat = 1'b0;
      mode = 1; run(1, 64, 11, 7, 0, 0);
      mode = 2; run(1, 64, 21, 0, 0, 0);
      mode = 3; run(1, 64, 7, 24, 0, 0);

      // Abort at pat=10 under stuck-at-1: fail from pattern 7 is retained.
      mode = 1;
      @(negedge clk); b1.start = 1'b1;
      @(negedge clk); b1.start = 1'b0;
      wait_pat1(10, 100);
      b1.abort = 1'b1;
      @(negedge clk); b1.abort = 1'b0;
      check("abort_busy", b1.busy, 0);
      check("abort_done", b1.done, 0);
      check("abort_pass", b1.pass, 0);
      check("abort_pat", b1.pat, 0);
      check("abort_fail_count", b1.fail_count, 1);
      check("abort_first_fail", b1.first_fail, 7);

      // Abort and start together: abort wins.
      @(negedge clk); b1.start = 1'b1; b1.abort = 1'b1;
      @(negedge clk); b1.start = 1'b0; b1.abort = 1'b0;
      check("abort_start_busy", b1.busy, 0);

      // Start while busy is ignored; completion time unchanged.
      mode = 0;
      run(1, 64, 0, 0, 1, 20);

      // Asynchronous reset mid-test at pat=20.
      @(negedge clk); b1.start = 1'b1;
      @(negedge clk); b1.start = 1'b0;
      wait_pat1(20, 100);
      #1 nreset = 1'b0;
      #1;
      check("nrst_pat", b1.pat, 0);
      check("nrst_busy", b1.busy, 0);
      check("nrst_done", b1.done, 0);
      check("nrst_fail_count", b1.fail_count, 0);
      @(negedge clk); nreset = 1'b1;

      // Other settle builds, each run twice (second run restarts from DONE).
      run(0, 32, 0, 0, 1, 0);
      run(0, 32, 0, 0, 1, 0);
      run(2, 128, 0, 0, 1, 0);
      run(2, 128, 0, 0, 1, 0);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/la_cellbist.md
Name: la_cellbist

Overview:
- Exhaustive built-in self-test sequencer for small stdlib combinational cells; default configuration targets the 5-input and-or-invert cell (a0,a1,a2,b0,b1 -> z).
- Sits directly around the cell under test (CUT):
  - Upstream: drives every input pattern into the CUT.
  - Downstream: samples and checks the CUT output against a parameterised truth table.
- Reports pass/fail, the number of failing patterns and the index of the first failure.
- Used for silicon bring-up of stdlib characterisation macros.

Parameters:
- N, 5, number of CUT inputs; 2^N patterns applied.
- TT, 32'h007F7F7F, expected truth table, width 2^N; bit i = expected z for pattern i. The default is the aoi32 function with pat[0]=a0, pat[1]=a1, pat[2]=a2, pat[3]=b0, pat[4]=b1.
- SETTLE, 1, wait cycles between applying a pattern and sampling z_in; range 0..15.
- PROP, "DEFAULT", implementation property string, passed through unused.

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- start  input  1  begin test; sampled only in IDLE or DONE
- abort  input  1  synchronous abandon; returns to IDLE
- z_in  input  1  CUT output
- pat  output  N  pattern driven to CUT inputs
- busy  output  1  test in progress
- done  output  1  test complete; level, held until next start/abort
- pass  output  1  done and zero failures
- fail_count  output  N+1  number of mismatching patterns, saturates at 2^N
- first_fail  output  N  index of first mismatching pattern; 0 if none

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (nreset). While nreset=0, all state and outputs are cleared: state=IDLE, pat=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0. Deassertion is used as-is; the integrator provides a synchronised deassertion.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE, start=1 at the edge:
  - pat<=0, fail_count<=0, first_fail<=0, done<=0, pass<=0, busy<=1.
  - Next state is APPLY (settle counter loaded with SETTLE-1), or SAMPLE if SETTLE=0.
- APPLY: pat held stable; settle counter decrements each cycle; at 0, go to SAMPLE.
- SAMPLE (one cycle): compare z_in against TT[pat].
  - On mismatch: fail_count<=fail_count+1; if fail_count was 0, first_fail<=pat.
  - If pat==2^N-1: go to DONE, busy<=0, done<=1, pass<=(no failures including this sample).
  - Otherwise: pat<=pat+1 (no wrap), go to APPLY/SAMPLE as from IDLE.
- Timing: each pattern occupies SETTLE+1 cycles. For default parameters, done rises exactly 2^N*(SETTLE+1)=64 clock edges after the edge that samples start.
- DONE: outputs held. start=1 restarts exactly as from IDLE; pat resets to 0 on that edge. pat remains 2^N-1 until then.
- start while busy: ignored; no restart, no effect on counters.
- abort=1 in any state: next edge state=IDLE, busy=0, done=0, pass=0, pat=0. fail_count and first_fail keep their last values for debug.
- abort and start in the same cycle: abort wins.
- nreset asserted mid-test: immediate clear as above; no partial result is reported.
- z_in is sampled only in SAMPLE; X or glitches in other states are ignored.
- fail_count is N+1 bits wide, so the maximum 2^N fits and never wraps.
- Pattern, settle and fail counters are plain binary registers; no combinational path from z_in to any output.

Test Plan:
- Fault-free aoi32 model on pat, defaults, start pulse -> busy=1 next cycle; done=1, pass=1, fail_count=0, first_fail=0 exactly 64 edges after start; pat sequence 0..31, each value held 2 cycles.
- z_in stuck-at-1 -> done, pass=0, fail_count=11, first_fail=7.
- z_in stuck-at-0 -> fail_count=21, first_fail=0.
- CUT model with b1 stuck-at-0 (z=~(a0&a1&a2)) -> fail_count=7, first_fail=24.
- Abort and reset mid-operation:
  - abort at pat=10 -> IDLE next edge, busy=0, done=0, pat=0, fail_count retained.
  - start during busy -> no restart; completes at the original 64-edge time.
  - nreset pulse at pat=20 -> all outputs 0 immediately.
- SETTLE=0 and SETTLE=3 builds, fault-free -> done at 32 and 128 edges respectively; restart from DONE reproduces identical results.
